dac_ltc2624_rx: RTL and testbench

- Synthesizable responder side of the LTC2624 SPI link driven by dacsend.
- Oversamples SPI_SCK, DAC_CS, dac_in and DAC_CLR on CLK50MHZ and deframes the 32-bit word.
- Decodes command, address and data, and maintains four channel input/DAC registers plus power-down flags.
- Echoes the previous valid frame on DAC_OUT, as the LTC2624 does.
- Used as a checkable DAC model in system benches and as a loopback target on hardware.

---
 rtl/dac_ltc2624_pkg.sv | 48 ++++
 rtl/dac_ltc2624_sync_edge.sv | 41 ++++
 rtl/dac_ltc2624_rx.sv | 195 +++++++++++++++++++
 tb/tb_dac_ltc2624_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_ltc2624_pkg.sv
// rtl/dac_ltc2624_pkg.sv - shared constants, field positions and FSM states for the LTC2624 responder
// Purpose : command/address codes, frame field positions, channel select helper, FSM state enum.
// Ports   : none (package).
package dac_ltc2624_pkg;

   localparam logic [3:0] CMD_WRITE            = 4'b0000;
   localparam logic [3:0] CMD_UPDATE           = 4'b0001;
   localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'b0010;
   localparam logic [3:0] CMD_WRITE_UPDATE     = 4'b0011;
   localparam logic [3:0] CMD_POWERDOWN        = 4'b0100;
   localparam logic [3:0] CMD_NOP              = 4'b1111;

   localparam logic [3:0] ADDR_A   = 4'b0000;
   localparam logic [3:0] ADDR_B   = 4'b0001;
   localparam logic [3:0] ADDR_C   = 4'b0010;
   localparam logic [3:0] ADDR_D   = 4'b0011;
   localparam logic [3:0] ADDR_ALL = 4'b1111;

   localparam int CMD_LSB  = 20;
   localparam int ADDR_LSB = 16;
   localparam int DATA_LSB = 4;
   localparam int DATA_W   = 12;
   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_APPLY,
      ST_ERR
   } state_e;

   // One-hot channel mask {D,C,B,A}; unused addresses select nothing.
   function automatic logic [NUM_CH-1:0] chan_sel(input logic [3:0] addr);
      logic [NUM_CH-1:0] sel;
      sel = '0;
      case (addr)
         ADDR_A:   sel = 4'b0001;
         ADDR_B:   sel = 4'b0010;
         ADDR_C:   sel = 4'b0100;
         ADDR_D:   sel = 4'b1000;
         ADDR_ALL: sel = 4'b1111;
         default:  sel = 4'b0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/dac_ltc2624_sync_edge.sv
// rtl/dac_ltc2624_sync_edge.sv - N-stage synchronizer with registered rise/fall pulses
// Purpose : bring one asynchronous input into the clk_i domain and flag its edges.
// Ports   : clk_i, rst_i (async, active-high), d_i (async input),
//           level_o (synchronized level, aligned with the edge pulses),
//           rise_o / fall_o (one-cycle pulses, one cycle after the synchronized value changes).
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic              rise_q;
   logic              fall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         hist_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~hist_q;
         fall_q <= ~sync_q[STAGES-1] & hist_q;
      end
   end

   // The history flop is reported as the level so level and pulses line up.
   assign level_o = hist_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/dac_ltc2624_rx.sv
// rtl/dac_ltc2624_rx.sv - LTC2624 SPI responder: deframes, decodes, holds channel registers, echoes
// Purpose : oversampled SPI slave modelling the LTC2624 quad DAC register file.
// Ports   : CLK50MHZ, RST (async, active-high), SPI_SCK, DAC_CS (active low), DAC_CLR (active low),
//           dac_in (MOSI), DAC_OUT (echo of previous valid frame), rx_command/rx_address/rx_data
//           (last valid frame), rx_valid / rx_error pulses, dac_value {D,C,B,A}, dac_pd {D,C,B,A}.
module dac_ltc2624_rx
   import dac_ltc2624_pkg::*;
#(
   parameter int FRAME_BITS  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK50MHZ,
   input  logic        RST,
   input  logic        SPI_SCK,
   input  logic        DAC_CS,
   input  logic        DAC_CLR,
   input  logic        dac_in,
   output logic        DAC_OUT,
   output logic [3:0]  rx_command,
   output logic [3:0]  rx_address,
   output logic [11:0] rx_data,
   output logic        rx_valid,
   output logic        rx_error,
   output logic [47:0] dac_value,
   output logic [3:0]  dac_pd
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

   logic sck_lvl_unused, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic din_lvl, unused_din_rise, unused_din_fall;
   logic clr_lvl, unused_clr_rise, unused_clr_fall;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk_i(CLK50MHZ), .rst_i(RST), .d_i(SPI_SCK),
      .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk_i(CLK50MHZ), .rst_i(RST), .d_i(DAC_CS),
      .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
      .clk_i(CLK50MHZ), .rst_i(RST), .d_i(dac_in),
      .level_o(din_lvl), .rise_o(unused_din_rise), .fall_o(unused_din_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .clk_i(CLK50MHZ), .rst_i(RST), .d_i(DAC_CLR),
      .level_o(clr_lvl), .rise_o(unused_clr_rise), .fall_o(unused_clr_fall));

   state_e                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]          rx_sr_q, rx_sr_d;
   logic [FRAME_BITS-1:0]          echo_sr_q, echo_sr_d;
   logic [FRAME_BITS-1:0]          echo_word_q, echo_word_d;
   logic [3:0]                     cmd_q, cmd_d;
   logic [3:0]                     addr_q, addr_d;
   logic [DATA_W-1:0]              data_q, data_d;
   logic [NUM_CH-1:0][DATA_W-1:0]  in_q, in_d;
   logic [NUM_CH-1:0][DATA_W-1:0]  dac_q, dac_d;
   logic [NUM_CH-1:0]              pd_q, pd_d;

   logic [3:0]        f_cmd;
   logic [3:0]        f_addr;
   logic [DATA_W-1:0] f_data;
   logic [NUM_CH-1:0] f_sel;

   assign f_cmd  = rx_sr_q[CMD_LSB +: 4];
   assign f_addr = rx_sr_q[ADDR_LSB +: 4];
   assign f_data = rx_sr_q[DATA_LSB +: DATA_W];
   assign f_sel  = chan_sel(f_addr);

   always_ff @(posedge CLK50MHZ or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rx_sr_q     <= '0;
         echo_sr_q   <= '0;
         echo_word_q <= '0;
         cmd_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         in_q        <= '0;
         dac_q       <= '0;
         pd_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_sr_q     <= rx_sr_d;
         echo_sr_q   <= echo_sr_d;
         echo_word_q <= echo_word_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         in_q        <= in_d;
         dac_q       <= dac_d;
         pd_q        <= pd_d;
      end
   end

   // The frame is decoded and executed on the SHIFT->APPLY transition so that
   // the registers and the rx_valid pulse (APPLY state) appear in the same cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_sr_d     = rx_sr_q;
      echo_sr_d   = echo_sr_q;
      echo_word_d = echo_word_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      in_d        = in_q;
      dac_d       = dac_q;
      pd_d        = pd_q;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_SHIFT;
               cnt_d     = '0;
               echo_sr_d = echo_word_q;
            end
         end
         ST_SHIFT: begin
            if (sck_rise) begin
               rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], din_lvl};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            if (sck_fall) echo_sr_d = {echo_sr_q[FRAME_BITS-2:0], 1'b0};
            if (cs_rise) begin
               if (cnt_q == CNT_FULL) begin
                  state_d     = ST_APPLY;
                  cmd_d       = f_cmd;
                  addr_d      = f_addr;
                  data_d      = f_data;
                  echo_word_d = rx_sr_q;
                  case (f_cmd)
                     CMD_WRITE: begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                           if (f_sel[ch]) in_d[ch] = f_data;
                     end
                     CMD_UPDATE: begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                           if (f_sel[ch]) begin
                              dac_d[ch] = in_q[ch];
                              pd_d[ch]  = 1'b0;
                           end
                     end
                     CMD_WRITE_UPDATE_ALL: begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                           if (f_sel[ch]) in_d[ch] = f_data;
                        dac_d = in_d;
                        pd_d  = '0;
                     end
                     CMD_WRITE_UPDATE: begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                           if (f_sel[ch]) begin
                              in_d[ch]  = f_data;
                              dac_d[ch] = f_data;
                              pd_d[ch]  = 1'b0;
                           end
                     end
                     CMD_POWERDOWN: begin
                        for (int ch = 0; ch < NUM_CH; ch++)
                           if (f_sel[ch]) pd_d[ch] = 1'b1;
                     end
                     default: ;
                  endcase
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_APPLY: state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Clear wins over any write landing in the same cycle; power-down flags survive.
      if (!clr_lvl) begin
         in_d  = '0;
         dac_d = '0;
      end
   end

   // Gated by SHIFT as well so the stale shift register is never seen in the
   // single cycle between the CS level dropping and the echo word being loaded.
   assign DAC_OUT    = echo_sr_q[FRAME_BITS-1] & ~cs_lvl & (state_q == ST_SHIFT);
   assign rx_command = cmd_q;
   assign rx_address = addr_q;
   assign rx_data    = data_q;
   assign rx_valid   = (state_q == ST_APPLY);
   assign rx_error   = (state_q == ST_ERR);
   assign dac_value  = dac_q;
   assign dac_pd     = pd_q;

endmodule

// File: tb/tb_dac_ltc2624_rx.sv
// tb/tb_dac_ltc2624_rx.sv - self-checking bench for dac_ltc2624_rx
module tb_dac_ltc2624_rx;

   localparam int SYNC = 2;
   localparam int H    = 5;

   logic        clk = 1'b0;
   logic        rst, sck, cs, clr, din;
   logic        dout;
   logic [3:0]  rx_command, rx_address;
   logic [11:0] rx_data;
   logic        rx_valid, rx_error;
   logic [47:0] dac_value;
   logic [3:0]  dac_pd;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_err = 0;

   logic [11:0] in_m [4];
   logic [11:0] dac_m [4];
   logic [3:0]  pd_m;
   logic [31:0] echo_m;
   logic [3:0]  cmd_m, addr_m;
   logic [11:0] data_m;

   dac_ltc2624_rx #(.FRAME_BITS(32), .SYNC_STAGES(SYNC)) dut (
      .CLK50MHZ(clk), .RST(rst), .SPI_SCK(sck), .DAC_CS(cs), .DAC_CLR(clr),
      .dac_in(din), .DAC_OUT(dout), .rx_command(rx_command), .rx_address(rx_address),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
      .dac_value(dac_value), .dac_pd(dac_pd));

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && rx_valid) n_valid <= n_valid + 1;
      if (!rst && rx_error) n_err <= n_err + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         in_m[c] = '0;
         dac_m[c] = '0;
      end
      pd_m = '0; echo_m = '0; cmd_m = '0; addr_m = '0; data_m = '0;
   endtask

   // Behaviour of one accepted frame, straight from the command table.
   task automatic model_apply(input logic [31:0] w);
      logic [3:0] c, a;
      logic [11:0] d;
      c = w[23:20]; a = w[19:16]; d = w[15:4];
      for (int ch = 0; ch < 4; ch++) begin
         if (a == 4'hF || a == ch[3:0]) begin
            case (c)
               4'h0: in_m[ch] = d;
               4'h1: begin dac_m[ch] = in_m[ch]; pd_m[ch] = 1'b0; end
               4'h2: in_m[ch] = d;
               4'h3: begin in_m[ch] = d; dac_m[ch] = d; pd_m[ch] = 1'b0; end
               4'h4: pd_m[ch] = 1'b1;
               default: ;
            endcase
         end
      end
      if (c == 4'h2) begin
         for (int ch = 0; ch < 4; ch++) dac_m[ch] = in_m[ch];
         pd_m = '0;
      end
      cmd_m = c; addr_m = a; data_m = d; echo_m = w;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".dac_value"}, {16'h0, dac_value}, {16'h0, dac_m[3], dac_m[2], dac_m[1], dac_m[0]});
      chk({tag, ".dac_pd"}, {60'h0, dac_pd}, {60'h0, pd_m});
      chk({tag, ".rx_fields"}, {44'h0, rx_command, rx_address, rx_data}, {44'h0, cmd_m, addr_m, data_m});
      chk({tag, ".dac_out_idle"}, {63'h0, dout}, 64'h0);
   endtask

   task automatic do_frame(input string tag, input logic [31:0] w, input int nbits);
      logic [63:0] obs, exp_e;
      int lat, v0, e0;
      bit good;
      obs = '0; exp_e = '0;
      v0 = n_valid; e0 = n_err;
      good = (nbits == 32);
      for (int i = 0; i < nbits && i < 64; i++) exp_e[63-i] = (i < 32) ? echo_m[31-i] : 1'b0;
      cs = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         din = (i < 32) ? w[31-i] : 1'b0;
         repeat (H) @(negedge clk);
         sck = 1'b1;
         repeat (H) @(negedge clk);
         if (i < 64) obs[63-i] = dout;
         sck = 1'b0;
      end
      repeat (H) @(negedge clk);
      cs = 1'b1; din = 1'b0;
      lat = 999;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (rx_valid || rx_error) begin lat = k; break; end
      end
      chk({tag, ".echo"}, obs, exp_e);
      chk({tag, ".latency"}, lat, SYNC + 2);
      chk({tag, ".kind"}, {62'h0, rx_valid, rx_error}, good ? 64'h2 : 64'h1);
      if (good) model_apply(w);
      repeat (4) @(negedge clk);
      chk({tag, ".n_valid"}, n_valid - v0, good ? 1 : 0);
      chk({tag, ".n_err"}, n_err - e0, good ? 0 : 1);
      check_state(tag);
   endtask

   function automatic logic [31:0] mkword(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
      logic [7:0] hi;
      logic [3:0] lo;
      hi = 8'($urandom);
      lo = 4'($urandom);
      return {hi, c, a, d, lo};
   endfunction

   initial begin
      logic [3:0] cmds [8];
      logic [3:0] c, a;
      rst = 1'b1; sck = 1'b0; cs = 1'b1; clr = 1'b1; din = 1'b0;
      cmds[0] = 4'h0; cmds[1] = 4'h1; cmds[2] = 4'h2; cmds[3] = 4'h3;
      cmds[4] = 4'h4; cmds[5] = 4'hF; cmds[6] = 4'h3; cmds[7] = 4'h0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset.dac_value", {16'h0, dac_value}, 64'h0);
      chk("reset.dac_pd", {60'h0, dac_pd}, 64'h0);
      chk("reset.pulses", {62'h0, rx_valid, rx_error}, 64'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_state("reset");

      do_frame("wu_a", {8'h00, 4'h3, 4'h0, 12'hABC, 4'h0}, 32);
      chk("wu_a.ch_a", {52'h0, dac_value[11:0]}, 64'hABC);

      do_frame("w_c", mkword(4'h0, 4'h2, 12'h123), 32);
      chk("w_c.ch_c", {52'h0, dac_value[35:24]}, 64'h0);
      do_frame("u_c", mkword(4'h1, 4'h2, 12'hFFF), 32);
      chk("u_c.ch_c", {52'h0, dac_value[35:24]}, 64'h123);

      do_frame("f1_all", mkword(4'h3, 4'hF, 12'h555), 32);
      chk("f1_all.value", {16'h0, dac_value}, {16'h0, 48'h555555555555});
      do_frame("f2_echo", mkword(4'hF, 4'h1, 12'($urandom)), 32);

      do_frame("err20", mkword(4'h3, 4'h0, 12'h111), 20);
      do_frame("err33", mkword(4'h3, 4'h0, 12'h222), 33);
      do_frame("err0", 32'h0, 0);

      do_frame("pd_all", mkword(4'h4, 4'hF, 12'h0), 32);
      chk("pd_all.pd", {60'h0, dac_pd}, 64'hF);
      do_frame("wu_b", mkword(4'h3, 4'h1, 12'h9A5), 32);
      chk("wu_b.pd", {60'h0, dac_pd}, 64'hD);

      do_frame("w_d", mkword(4'h0, 4'h3, 12'h777), 32);
      clr = 1'b0;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      repeat (10) @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin in_m[ch] = '0; dac_m[ch] = '0; end
      check_state("clr");
      do_frame("u_all_after_clr", mkword(4'h1, 4'hF, 12'hABC), 32);

      for (int n = 0; n < 12; n++) begin
         c = cmds[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0) c = 4'($urandom);
         a = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         do_frame("rand", mkword(c, a, 12'($urandom)), 32);
      end
      do_frame("rand_err", mkword(4'h3, 4'hF, 12'h0), $urandom_range(1, 31));

      cs = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         din = 1'($urandom);
         repeat (H) @(negedge clk);
         sck = 1'b1;
         repeat (H) @(negedge clk);
         sck = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("rst_mid.dac_value", {16'h0, dac_value}, 64'h0);
      chk("rst_mid.dac_pd", {60'h0, dac_pd}, 64'h0);
      chk("rst_mid.fields", {44'h0, rx_command, rx_address, rx_data}, 64'h0);
      chk("rst_mid.outs", {61'h0, rx_valid, rx_error, dout}, 64'h0);
      cs = 1'b1; din = 1'b0;
      repeat (3) @(negedge clk);
      begin
         int v0, e0;
         v0 = n_valid; e0 = n_err;
         rst = 1'b0;
         model_reset();
         repeat (12) @(negedge clk);
         chk("rst_mid.no_pulse", {n_valid - v0, n_err - e0}, 64'h0);
      end
      do_frame("after_rst", mkword(4'h2, 4'h2, 12'h4C7), 32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
